// File: rtl/truth_sweep_pkg.sv
// rtl/truth_sweep_pkg.sv - shared types and constants for the truth table sweeper
package truth_sweep_pkg;

  localparam int N_IN_DEFAULT = 4;
  localparam int D            = 1 << N_IN_DEFAULT;
  localparam int SETTLE_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  function automatic int depth(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - loadable up-counter with clear and terminal-count flag
module sweep_settle_timer
  import truth_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                en,
  input  logic [SETTLE_W-1:0] limit,
  output logic                tc
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweep, capture and compare of a combinational block
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [(1<<N_IN)-1:0]  expected,
  input  logic                  f_in,
  output logic [N_IN-1:0]       stim,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [(1<<N_IN)-1:0]  table_out,
  output logic [N_IN:0]         mismatch_cnt,
  output logic                  fail_valid,
  output logic [N_IN-1:0]       first_fail_idx
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0]     STIM_LAST    = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LIMIT = SETTLE_W'(SETTLE_CYCLES - 1);

  sweep_state_e       state;
  logic [DEPTH-1:0]   exp_q;
  logic               accept;
  logic               tmr_clear;
  logic               tmr_en;
  logic               tmr_tc;

  assign accept    = ((state == IDLE) || (state == DONE)) && start;
  // The settle count restarts at every new vector: on the accepting edge and after each sample.
  assign tmr_clear = accept || (state == SAMPLE);
  assign tmr_en    = (state == SETTLE);

  sweep_settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clear),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmr_en),
    .limit    (SETTLE_LIMIT),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      stim           <= '0;
      table_out      <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail_valid     <= 1'b0;
      exp_q          <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            exp_q          <= expected;
            table_out      <= '0;
            mismatch_cnt   <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            done           <= 1'b0;
            busy           <= 1'b1;
            stim           <= '0;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_out[stim] <= f_in;
          if (f_in != exp_q[stim]) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
            if (!fail_valid) begin
              first_fail_idx <= stim;
              fail_valid     <= 1'b1;
            end
          end
          // stim parks on the last vector rather than wrapping back to 0.
          if (stim == STIM_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            stim  <= stim + 1'b1;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper
module tb_truth_table_sweeper;

  typedef struct {
    logic [15:0] tbl;
    int          cnt;
    logic        fv;
    int          ffi;
    logic        pass;
    int          lat;
    int          d;
    int          sc;
    longint      start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  longint cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: defaults (N_IN = 4, SETTLE_CYCLES = 2)
  logic        start0;
  logic [15:0] exp0, func0, table0;
  logic [3:0]  stim0, ffi0;
  logic [4:0]  mm0;
  logic        busy0, done0, pass0, fv0, f0;
  assign f0 = func0[stim0];

  truth_table_sweeper u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .f_in(f0),
    .stim(stim0), .busy(busy0), .done(done0), .pass(pass0), .table_out(table0),
    .mismatch_cnt(mm0), .fail_valid(fv0), .first_fail_idx(ffi0)
  );

  // Instance 1: N_IN = 3, SETTLE_CYCLES = 1
  logic       start1;
  logic [7:0] exp1, func1, table1;
  logic [2:0] stim1, ffi1;
  logic [3:0] mm1;
  logic       busy1, done1, pass1, fv1, f1;
  assign f1 = func1[stim1];

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .f_in(f1),
    .stim(stim1), .busy(busy1), .done(done1), .pass(pass1), .table_out(table1),
    .mismatch_cnt(mm1), .fail_valid(fv1), .first_fail_idx(ffi1)
  );

  exp_t sb0[$];
  exp_t sb1[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: what a correct sweep of table fn against ex must report.
  function automatic exp_t model(input logic [15:0] fn, input logic [15:0] ex,
                                 input int n_in, input int sc);
    exp_t r;
    logic [15:0] mask;
    r.d    = 1 << n_in;
    r.sc   = sc;
    mask   = 16'((32'd1 << r.d) - 1);
    r.tbl  = fn & mask;
    r.cnt  = $countones((fn ^ ex) & mask);
    r.fv   = (r.cnt != 0);
    r.ffi  = 0;
    for (int i = r.d - 1; i >= 0; i--) if (fn[i] != ex[i]) r.ffi = i;
    r.pass = (r.cnt == 0);
    r.lat  = r.d * (sc + 1);
    r.start_cyc = 0;
    return r;
  endfunction

  task automatic verify(input string tag, input exp_t it, input logic [15:0] tbl, input int cnt,
                        input logic fv, input int ffi, input logic ps, input longint lat,
                        input int stim_end, input int bad);
    check({tag, "_table"}, tbl, it.tbl);
    check({tag, "_mismatch_cnt"}, cnt, it.cnt);
    check({tag, "_fail_valid"}, fv, it.fv);
    check({tag, "_first_fail_idx"}, ffi, it.ffi);
    check({tag, "_pass"}, ps, it.pass);
    check({tag, "_latency"}, lat, it.lat);
    check({tag, "_stim_final"}, stim_end, it.d - 1);
    check({tag, "_stim_walk_errs"}, bad, 0);
  endtask

  initial begin : mon0
    int bad;
    bit dprev;
    exp_t it;
    longint k;
    bad = 0;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy0 && sb0.size() > 0) begin
        k = cyc - sb0[0].start_cyc;
        if (longint'(stim0) != k / (sb0[0].sc + 1)) bad++;
      end
      if (done0 && !dprev) begin
        if (sb0.size() == 0) check("dut0_unexpected_done", 1, 0);
        else begin
          it = sb0.pop_front();
          verify("dut0", it, table0, int'(mm0), fv0, int'(ffi0), pass0,
                 cyc - it.start_cyc, int'(stim0), bad);
        end
        bad = 0;
      end
      dprev = done0;
    end
  end

  initial begin : mon1
    int bad;
    bit dprev;
    exp_t it;
    longint k;
    bad = 0;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy1 && sb1.size() > 0) begin
        k = cyc - sb1[0].start_cyc;
        if (longint'(stim1) != k / (sb1[0].sc + 1)) bad++;
      end
      if (done1 && !dprev) begin
        if (sb1.size() == 0) check("dut1_unexpected_done", 1, 0);
        else begin
          it = sb1.pop_front();
          verify("dut1", it, {8'h00, table1}, int'(mm1), fv1, int'(ffi1), pass1,
                 cyc - it.start_cyc, int'(stim1), bad);
        end
        bad = 0;
      end
      dprev = done1;
    end
  end

  task automatic start_sweep0(input logic [15:0] fn, input logic [15:0] ex);
    exp_t e;
    @(negedge clk);
    func0 = fn;
    exp0 = ex;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    e = model(fn, ex, 4, 2);
    e.start_cyc = cyc;
    sb0.push_back(e);
    exp0 = 16'($urandom);
  endtask

  task automatic start_sweep1(input logic [7:0] fn, input logic [7:0] ex);
    exp_t e;
    @(negedge clk);
    func1 = fn;
    exp1 = ex;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    e = model({8'h00, fn}, {8'h00, ex}, 3, 1);
    e.start_cyc = cyc;
    sb1.push_back(e);
    exp1 = 8'($urandom);
  endtask

  task automatic drain(input int which);
    for (int i = 0; i < 300 && ((which == 0) ? sb0.size() : sb1.size()) != 0; i++)
      @(negedge clk);
    check((which == 0) ? "dut0_timeout" : "dut1_timeout",
          (which == 0) ? sb0.size() : sb1.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_idle0(input string tag);
    check({tag, "_stim"}, stim0, 0);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_pass"}, pass0, 0);
    check({tag, "_table"}, table0, 0);
    check({tag, "_mismatch_cnt"}, mm0, 0);
    check({tag, "_fail_valid"}, fv0, 0);
    check({tag, "_first_fail_idx"}, ffi0, 0);
  endtask

  initial begin
    logic [15:0] fn16;
    logic [7:0]  fn8;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    exp0 = 16'h0; func0 = 16'h0;
    exp1 = 8'h0;  func1 = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle0("reset");
    check("reset_dut1_done", done1, 0);
    rst_n = 1'b1;

    // Matching block, single fault at bit 9, fully inverted block
    start_sweep0(16'hA5C3, 16'hA5C3);
    drain(0);
    start_sweep0(16'hA5C3 ^ 16'h0200, 16'hA5C3);
    drain(0);
    start_sweep0(16'hFFFF, 16'h0000);
    drain(0);

    // Start pulsed mid-sweep is ignored; then a restart from DONE
    start_sweep0(16'h3C5A, 16'h3C4A);
    repeat (19) @(negedge clk);
    exp0 = 16'h1234;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    drain(0);
    start_sweep0(16'h3C5A, 16'h3C5A);
    drain(0);

    // Reset mid-sweep discards the partial result
    start_sweep0(16'hBEEF, 16'h0F0F);
    repeat (24) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb0.delete();
    @(negedge clk);
    check_idle0("midreset");
    start_sweep0(16'hBEEF, 16'hBEEF);
    drain(0);

    for (int n = 0; n < 6; n++) begin
      fn16 = 16'($urandom);
      start_sweep0(fn16, fn16 ^ 16'($urandom & $urandom & $urandom));
      drain(0);
    end

    // Smaller instance: XOR3 and random tables
    start_sweep1(8'h96, 8'h96);
    drain(1);
    for (int n = 0; n < 4; n++) begin
      fn8 = 8'($urandom);
      start_sweep1(fn8, fn8 ^ 8'($urandom & $urandom));
      drain(1);
    end

    check("sb0_leftover", sb0.size(), 0);
    check("sb1_leftover", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
